// File: rtl/ccff_chain_loader_pkg.sv
// ccff_chain_loader_pkg
//   Shared definitions for the configuration-chain loader: the loader state
//   enumeration and the default bitstream word width and chain length.
package ccff_chain_loader_pkg;

  localparam int unsigned DEFAULT_WORD_W    = 8;
  localparam int unsigned DEFAULT_CHAIN_LEN = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/ccff_rb_deserializer.sv
// ccff_rb_deserializer
//   Collects the bits returned from the chain's ccff_tail, MSB first, into
//   WORD_W-bit readback words. A final partial word is emitted left-aligned.
//   No backpressure: rb_valid is a one-cycle pulse.
//   Only compiled when CCFF_CHAIN_LOADER_READBACK_EN is defined.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - discard any partially captured word (new load accepted)
//   capture     - sample tail_bit this cycle
//   last        - this capture is the final bit of the load
//   tail_bit    - serial bit from the chain tail
//   rb_data     - captured word
//   rb_valid    - rb_data valid (one-cycle pulse)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
module ccff_rb_deserializer
  import ccff_chain_loader_pkg::*;
#(
  parameter int unsigned WORD_W = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              capture,
  input  logic              last,
  input  logic              tail_bit,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  align;
  logic              full;

  assign acc_next = (acc_q << 1) | WORD_W'(tail_bit);
  assign full     = (cnt_q == CNT_W'(WORD_W - 1));
  // Left-align a short final word: cnt_q+1 bits captured, pad the rest.
  assign align    = CNT_W'(WORD_W - 1) - cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (capture) begin
        if (full || last) begin
          rb_data  <= acc_next << align;
          rb_valid <= 1'b1;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Serialises bitstream words into a configuration flip-flop chain of
//   CHAIN_LEN bits, MSB of each word first, with no bubbles between words.
//   Optional readback of the previous chain contents via ccff_tail is
//   enabled by defining CCFF_CHAIN_LOADER_READBACK_EN.
// Ports:
//   prog_clk   - clock
//   pReset_n   - asynchronous active-low reset
//   start      - one-cycle load request (honoured in IDLE and ERR)
//   bs_data    - bitstream word; bs_valid/bs_ready handshake
//   ccff_head  - registered serial bit into the chain
//   ccff_tail  - serial bit returned from the chain (readback only)
//   busy       - load in progress
//   done       - one-cycle pulse after CHAIN_LEN bits
//   err        - sticky underrun flag, cleared by the next accepted start
//   rb_data, rb_valid - readback words (macro builds only)
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = DEFAULT_WORD_W,
  parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              head_q;
  logic              err_q;
  logic              word_end;
  logic              chain_full;
  logic              start_ok;

  // The word's MSB goes straight to ccff_head on the transfer edge, so
  // bit_cnt/wcnt count bits already presented, including the one on
  // ccff_head now. The shift register holds only the remaining bits.
  assign word_end   = (wcnt_q == WCNT_W'(WORD_W));
  assign chain_full = (bit_cnt_q == CNT_W'(CHAIN_LEN));
  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));

  always_comb begin
    state_d  = state_q;
    bs_ready = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        bs_ready = 1'b1;
        if (bs_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (chain_full) begin
          state_d = ST_DONE;
        end else if (word_end) begin
          bs_ready = 1'b1;
          if (!bs_valid) state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      wcnt_q    <= '0;
      bit_cnt_q <= '0;
      head_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            err_q     <= 1'b0;
            bit_cnt_q <= '0;
            wcnt_q    <= '0;
            shreg_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (bs_valid) begin
            head_q    <= bs_data[WORD_W-1];
            shreg_q   <= bs_data << 1;
            wcnt_q    <= WCNT_W'(1);
            bit_cnt_q <= CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (chain_full) begin
            head_q <= 1'b0;
          end else if (word_end) begin
            if (bs_valid) begin
              head_q    <= bs_data[WORD_W-1];
              shreg_q   <= bs_data << 1;
              wcnt_q    <= WCNT_W'(1);
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else begin
              err_q  <= 1'b1;
              head_q <= 1'b0;
            end
          end else begin
            head_q    <= shreg_q[WORD_W-1];
            shreg_q   <= shreg_q << 1;
            wcnt_q    <= wcnt_q + WCNT_W'(1);
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ccff_head = head_q;
  assign err       = err_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  ccff_rb_deserializer #(
    .WORD_W (WORD_W)
  ) u_rb (
    .clk      (prog_clk),
    .rst_n    (pReset_n),
    .clear    (start_ok),
    .capture  (state_q == ST_SHIFT),
    .last     (chain_full),
    .tail_bit (ccff_tail),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );
`else
  logic tail_unused;
  logic start_ok_unused;
  assign tail_unused     = ccff_tail;
  assign start_ok_unused = start_ok;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  localparam int unsigned W  = 8;
  localparam int unsigned CL = 20;

  logic         prog_clk = 1'b0;
  logic         pReset_n = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] bs_data  = '0;
  logic         bs_valid = 1'b0;
  logic         bs_ready, ccff_head, ccff_tail, busy, done, err;

  logic         start2 = 1'b0;
  logic [W-1:0] data2  = '0;
  logic         valid2 = 1'b0;
  logic         tail2  = 1'b0;
  logic         rdy2, head2, busy2, done2, err2;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [W-1:0] rb_data, rb2_data_unused;
  logic         rb_valid, rb2_valid_unused;
`endif

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(CL)) u_dut (
    .prog_clk (prog_clk), .pReset_n (pReset_n), .start (start),
    .bs_data (bs_data), .bs_valid (bs_valid), .bs_ready (bs_ready),
    .ccff_head (ccff_head), .ccff_tail (ccff_tail), .busy (busy),
    .done (done), .err (err)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    , .rb_data (rb_data), .rb_valid (rb_valid)
`endif
  );

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(8)) u_dut8 (
    .prog_clk (prog_clk), .pReset_n (pReset_n), .start (start2),
    .bs_data (data2), .bs_valid (valid2), .bs_ready (rdy2),
    .ccff_head (head2), .ccff_tail (tail2), .busy (busy2),
    .done (done2), .err (err2)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    , .rb_data (rb2_data_unused), .rb_valid (rb2_valid_unused)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 20-bit loader ----------------
  // Pending bits of accepted words live in a queue; a word is requested only
  // once the queue has drained and more chain bits are still needed.
  bit m_wait, m_stream, m_done, m_err, m_head;
  int m_sent;
  bit q[$];

  function automatic bit m_ready();
    return m_wait || (m_stream && q.size() == 0 && m_sent < CL);
  endfunction

  function automatic void push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
  endfunction

  always @(posedge prog_clk or negedge pReset_n) begin
    bit rdy, was_done;
    if (!pReset_n) begin
      m_wait = 0; m_stream = 0; m_done = 0; m_err = 0; m_head = 0; m_sent = 0;
      q.delete();
    end else begin
      rdy = m_ready();
      was_done = m_done;
      m_done = 0;
      if (m_wait) begin
        if (bs_valid) begin
          push_word(bs_data);
          m_head = q.pop_front();
          m_sent = 1; m_wait = 0; m_stream = 1;
        end
      end else if (m_stream) begin
        if (m_sent == CL) begin
          m_stream = 0; m_done = 1; m_head = 0; q.delete();
        end else if (rdy && !bs_valid) begin
          m_stream = 0; m_err = 1; m_head = 0;
        end else begin
          if (rdy) push_word(bs_data);
          m_head = q.pop_front();
          m_sent++;
        end
      end else if (!was_done && start) begin
        m_wait = 1; m_err = 0; m_sent = 0; q.delete();
      end
    end
  end

  // ---------------- per-cycle compare and observation ----------------
  bit rec[$];
  int n_xfer, n_done;

  always @(negedge prog_clk) begin
    check("ccff_head", 32'(ccff_head), 32'(m_head));
    check("bs_ready",  32'(bs_ready),  32'(m_ready()));
    check("busy",      32'(busy),      32'(m_wait || m_stream));
    check("done",      32'(done),      32'(m_done));
    check("err",       32'(err),       32'(m_err));
    if (m_stream) rec.push_back(ccff_head);
    if (done) n_done++;
    if (bs_valid && bs_ready) n_xfer++;
  end

  function automatic logic [31:0] pack_rec();
    logic [31:0] v = '0;
    foreach (rec[i]) v = {v[30:0], rec[i]};
    return v;
  endfunction

  // ---------------- external chain model for readback ----------------
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [CL-1:0] chain = '0;
  logic          load_phase;
  logic [W-1:0]  rb_list[$];
  assign ccff_tail = chain[CL-1];

  always @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) load_phase <= 1'b0;
    else if (start && !busy && !done) load_phase <= 1'b1;
    else if (load_phase && bs_valid && bs_ready) load_phase <= 1'b0;
  end

  always @(posedge prog_clk)
    if (busy && !load_phase) chain <= {chain[CL-2:0], ccff_head};

  always @(negedge prog_clk)
    if (rb_valid) rb_list.push_back(rb_data);
`else
  assign ccff_tail = 1'b0;
`endif

  // ---------------- stimulus ----------------
  logic [W-1:0] words[3] = '{8'hA5, 8'h3C, 8'hF0};

  task automatic run_load(input int n_words, input int poke_at, input int abort_bits,
                          output bit timed_out);
    int idx = 0;
    timed_out = 1;
    rec.delete(); n_xfer = 0; n_done = 0;
    @(negedge prog_clk); #1;
    start = 1'b1; bs_valid = 1'b1; bs_data = words[0];
    @(posedge prog_clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge prog_clk);
      start = (cyc == poke_at);
      if (!m_wait && !m_stream && !m_done) begin
        timed_out = 0;
        break;
      end
      if (abort_bits > 0 && m_sent == abort_bits) begin
        #2; pReset_n = 1'b0; start = 1'b0; bs_valid = 1'b0;
        #1;
        check("rst ccff_head", 32'(ccff_head), 0);
        check("rst bs_ready",  32'(bs_ready),  0);
        check("rst busy",      32'(busy),      0);
        check("rst done",      32'(done),      0);
        check("rst err",       32'(err),       0);
        @(negedge prog_clk); @(negedge prog_clk); #2;
        pReset_n = 1'b1;
        timed_out = 0;
        break;
      end
      if (bs_valid && bs_ready) begin
        @(posedge prog_clk); #1;
        idx++;
        if (idx < n_words) bs_data = words[idx];
        else bs_valid = 1'b0;
      end
    end
    start = 1'b0; bs_valid = 1'b0;
    check("load timeout", 32'(timed_out), 0);
  endtask

  initial begin
    bit to;
    logic [W-1:0] exp8;

    repeat (3) @(negedge prog_clk);
    check("reset head", 32'(ccff_head), 0);
    check("reset ready", 32'(bs_ready), 0);
    check("reset busy", 32'({busy, done, err}), 0);
    #2 pReset_n = 1'b1;

    // Nominal 20-bit load from three words.
    run_load(3, -1, 0, to);
    check("seq bits", pack_rec(), 32'hA53CF);
    check("seq len", 32'(rec.size()), 20);
    check("xfers", 32'(n_xfer), 3);
    check("done pulses", 32'(n_done), 1);
    check("err after load", 32'(err), 0);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    // Reload: readback returns the previous image, final word left-aligned.
    rb_list.delete();
    run_load(3, -1, 0, to);
    repeat (2) @(negedge prog_clk);
    check("rb count", 32'(rb_list.size()), 3);
    if (rb_list.size() == 3) begin
      check("rb word0", 32'(rb_list[0]), 32'hA5);
      check("rb word1", 32'(rb_list[1]), 32'h3C);
      check("rb word2", 32'(rb_list[2]), 32'hF0);
    end
`endif

    // start while busy is ignored.
    run_load(3, 6, 0, to);
    check("poke bits", pack_rec(), 32'hA53CF);
    check("poke done", 32'(n_done), 1);
    check("poke xfers", 32'(n_xfer), 3);

    // Underrun on the second word.
    run_load(1, -1, 0, to);
    check("underrun bits", pack_rec(), 32'hA5);
    check("underrun done", 32'(n_done), 0);
    check("underrun xfers", 32'(n_xfer), 1);
    repeat (3) @(negedge prog_clk);
    check("err sticky", 32'(err), 1);
    check("err not busy", 32'(busy), 0);
    run_load(3, -1, 0, to);
    check("err cleared", 32'(err), 0);
    check("recover done", 32'(n_done), 1);
    check("recover bits", pack_rec(), 32'hA53CF);

    // Reset after 10 bits, then a clean load.
    run_load(3, -1, 10, to);
    check("abort done", 32'(n_done), 0);
    check("abort bits", 32'(rec.size()), 10);
    run_load(3, -1, 0, to);
    check("post-abort bits", pack_rec(), 32'hA53CF);
    check("post-abort done", 32'(n_done), 1);

    // CHAIN_LEN=8: one word, no re-request.
    exp8 = 8'h81;
    @(negedge prog_clk); start2 = 1'b1;
    @(negedge prog_clk); start2 = 1'b0;
    check("c8 ready load", 32'(rdy2), 1);
    check("c8 busy load", 32'(busy2), 1);
    valid2 = 1'b1; data2 = 8'h81;
    @(posedge prog_clk); #1 valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge prog_clk);
      check("c8 head", 32'(head2), 32'(exp8[7-i]));
      check("c8 ready", 32'(rdy2), 0);
      check("c8 busy", 32'(busy2), 1);
    end
    @(negedge prog_clk);
    check("c8 done", 32'(done2), 1);
    check("c8 head idle", 32'(head2), 0);
    check("c8 busy end", 32'(busy2), 0);
    @(negedge prog_clk);
    check("c8 done pulse", 32'(done2), 0);
    check("c8 err", 32'(err2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
